// File: rtl/mul_share_arbiter.sv
`timescale 1ns/1ps
// mul_share_arbiter
// Round-robin arbiter plus 2-stage pipeline controller that time-shares one
// signed din0_WIDTH x din1_WIDTH multiplier between NUM_REQ requesters.
// Products return on a single response channel tagged with the requester index.
//
// Ports:
//   ap_clk      rising-edge clock
//   ap_rst_n    asynchronous active-low reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept (one-hot or zero)
//   req_din0    packed operand A, requester i at [i*din0_WIDTH +: din0_WIDTH]
//   req_din1    packed operand B, requester i at [i*din1_WIDTH +: din1_WIDTH]
//   resp_valid  product available
//   resp_ready  consumer accepts product
//   resp_id     requester index that issued the product
//   resp_dout   signed full-precision product
//   op_count    completed response handshakes, wraps at 16 bits
module mul_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 13,
    parameter int dout_WIDTH = 29
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*din0_WIDTH-1:0] req_din0,
    input  logic [NUM_REQ*din1_WIDTH-1:0] req_din1,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_WIDTH-1:0]           resp_id,
    output logic [dout_WIDTH-1:0]         resp_dout,
    output logic [15:0]                   op_count
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                          r_s1_valid;
    logic signed [din0_WIDTH-1:0]  r_s1_a;
    logic signed [din1_WIDTH-1:0]  r_s1_b;
    logic [ID_WIDTH-1:0]           r_s1_id;
    logic                          r_s2_valid;
    logic signed [dout_WIDTH-1:0]  r_s2_p;
    logic [ID_WIDTH-1:0]           r_s2_id;
    logic [ID_WIDTH-1:0]           r_last_grant;
    logic [15:0]                   r_op_count;

    logic signed [din0_WIDTH-1:0]  w_din0 [NUM_REQ];
    logic signed [din1_WIDTH-1:0]  w_din1 [NUM_REQ];
    logic [dout_WIDTH-1:0]         w_prod;
    logic                          w_adv1;
    logic                          w_adv2;
    logic                          w_accept;
    logic                          w_any;
    logic [SEL_W-1:0]              w_gidx;
    logic [SEL_W-1:0]              w_sel;
    int                            w_pos;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_din0[gi] = req_din0[gi*din0_WIDTH +: din0_WIDTH];
        assign w_din1[gi] = req_din1[gi*din1_WIDTH +: din1_WIDTH];
    end

    assign w_adv2   = !r_s2_valid || resp_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign w_accept = w_any && w_adv1;

    // Walk the candidates from lowest to highest priority so the last hit,
    // i.e. the first valid index after r_last_grant, is the one that sticks.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_pos  = 0;
        w_sel  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = (int'(r_last_grant) + k) % NUM_REQ;
            w_sel = SEL_W'(w_pos);
            if (req_valid[w_sel]) begin
                w_any  = 1'b1;
                w_gidx = w_sel;
            end
        end
    end

    // Ready is forced low while reset is held, since adv1 alone would be high
    // with both stages cleared.
    always_comb begin
        req_ready = '0;
        if (w_accept && ap_rst_n) begin
            req_ready[w_gidx] = 1'b1;
        end
    end

    myproject_mul_16s_13s_29_1_1 #(
        .din0_WIDTH (din0_WIDTH),
        .din1_WIDTH (din1_WIDTH),
        .dout_WIDTH (dout_WIDTH)
    ) u_mul (
        .din0 (r_s1_a),
        .din1 (r_s1_b),
        .dout (w_prod)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_id      <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_p       <= '0;
            r_s2_id      <= '0;
            r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
            r_op_count   <= '0;
        end else begin
            // S1: operand capture from the granted requester
            if (w_adv1) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_a       <= w_din0[w_gidx];
                    r_s1_b       <= w_din1[w_gidx];
                    r_s1_id      <= ID_WIDTH'(w_gidx);
                    r_last_grant <= ID_WIDTH'(w_gidx);
                end
            end
            // S2: product register driving the response channel
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_p  <= w_prod;
                    r_s2_id <= r_s1_id;
                end
            end
            if (r_s2_valid && resp_ready) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign resp_valid = r_s2_valid;
    assign resp_dout  = r_s2_p;
    assign resp_id    = r_s2_id;
    assign op_count   = r_op_count;

endmodule

// myproject_mul_16s_13s_29_1_1
// Combinational signed multiplier; both operands are sign-extended to the
// product width so the full-precision product is produced without truncation.
// Ports: din0 (signed A), din1 (signed B), dout (signed A*B).
module myproject_mul_16s_13s_29_1_1 #(
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 13,
    parameter int dout_WIDTH = 29
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);
    logic signed [dout_WIDTH-1:0] w_a_ext;
    logic signed [dout_WIDTH-1:0] w_b_ext;

    assign w_a_ext = dout_WIDTH'($signed(din0));
    assign w_b_ext = dout_WIDTH'($signed(din1));
    assign dout    = w_a_ext * w_b_ext;

endmodule

// File: tb/tb_mul_share_arbiter.sv
`timescale 1ns/1ps
// Testbench for mul_share_arbiter: a queue-based reference model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_mul_share_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int AW  = 16;
    localparam int BW  = 13;
    localparam int PW  = 29;

    logic            ap_clk;
    logic            ap_rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_din0;
    logic [N*BW-1:0] req_din1;
    logic            resp_valid;
    logic            resp_ready;
    logic [IDW-1:0]  resp_id;
    logic [PW-1:0]   resp_dout;
    logic [15:0]     op_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mul_share_arbiter #(
        .NUM_REQ    (N),
        .ID_WIDTH   (IDW),
        .din0_WIDTH (AW),
        .din1_WIDTH (BW),
        .dout_WIDTH (PW)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_din0   (req_din0),
        .req_din1   (req_din1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_dout  (resp_dout),
        .op_count   (op_count)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic chk(input string name, input longint got, input longint exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", name, got, exp);
    endtask

    // Reference model: in-flight products form a FIFO of at most two entries.
    // The oldest entry is visible one edge after it was accepted; a new
    // request is taken when fewer than two are in flight or the head leaves.
    typedef struct {
        int     id;
        longint p;
        int     age;
    } item_t;

    item_t  mq[$];
    item_t  m_it;
    int     m_last = N - 1;
    int     m_g;
    int     m_idx;
    bit     m_any;
    bit     m_vis;
    bit     m_hs;
    bit     m_acc;
    longint m_cnt = 0;

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            mq.delete();
            m_last = N - 1;
            m_cnt  = 0;
            chk("rst_req_ready", longint'(req_ready), 0);
            chk("rst_resp_valid", longint'(resp_valid), 0);
            chk("rst_resp_id", longint'(resp_id), 0);
            chk("rst_resp_dout", longint'(resp_dout), 0);
            chk("rst_op_count", longint'(op_count), 0);
        end else begin
            m_any = 1'b0;
            m_g   = 0;
            for (int k = 1; k <= N; k++) begin
                m_idx = (m_last + k) % N;
                if (!m_any && req_valid[m_idx[IDW-1:0]]) begin
                    m_any = 1'b1;
                    m_g   = m_idx;
                end
            end
            m_vis = (mq.size() > 0) && (mq[0].age >= 1);
            m_hs  = m_vis && resp_ready;
            m_acc = m_any && ((mq.size() < 2) || m_hs);
            chk("req_ready", longint'(req_ready), m_acc ? (longint'(1) << m_g) : 0);
            chk("resp_valid", longint'(resp_valid), longint'(m_vis));
            if (m_vis) begin
                chk("resp_id", longint'(resp_id), longint'(mq[0].id));
                chk("resp_dout", longint'($signed(resp_dout)), mq[0].p);
            end
            chk("op_count", longint'(op_count), m_cnt % 65536);
            if (m_hs) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            foreach (mq[i]) mq[i].age++;
            if (m_acc) begin
                m_it.id  = m_g;
                m_it.p   = longint'($signed(req_din0[m_g*AW +: AW])) *
                           longint'($signed(req_din1[m_g*BW +: BW]));
                m_it.age = 0;
                mq.push_back(m_it);
                m_last = m_g;
            end
        end
    end

    task automatic set_ops(input int i, input longint a, input longint b);
        req_din0[i*AW +: AW] = AW'(a);
        req_din1[i*BW +: BW] = BW'(b);
    endtask

    // One request from requester id into an empty pipeline, resp_ready high.
    task automatic single(input int id, input longint a, input longint b, input longint exp_p);
        @(posedge ap_clk); #1;
        set_ops(id, a, b);
        req_valid[id] = 1'b1;
        @(posedge ap_clk); #1;
        req_valid[id] = 1'b0;
        @(negedge ap_clk);
        chk("single_early_valid", longint'(resp_valid), 0);
        @(negedge ap_clk);
        chk("single_valid", longint'(resp_valid), 1);
        chk("single_id", longint'(resp_id), longint'(id));
        chk("single_dout", longint'($signed(resp_dout)), exp_p);
    endtask

    task automatic do_reset();
        @(posedge ap_clk); #1;
        ap_rst_n  = 1'b0;
        req_valid = '0;
        @(posedge ap_clk); #1;
    endtask

    int order [6];
    int acc_cnt;

    initial begin
        ap_rst_n   = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        req_din0   = '0;
        req_din1   = '0;
        order      = '{0, 1, 2, 3, 0, 1};
        #1 ap_rst_n = 1'b0;

        // Reset holds ready low even with every requester valid
        @(negedge ap_clk);
        chk("t0_reset_ready", longint'(req_ready), 0);
        chk("t0_reset_valid", longint'(resp_valid), 0);

        // Test 1: single request from requester 2
        @(posedge ap_clk); #1;
        ap_rst_n  = 1'b1;
        req_valid = '0;
        set_ops(2, -32768, -4096);
        req_valid[2] = 1'b1;
        @(negedge ap_clk);
        chk("t1_grant", longint'(req_ready), 4);
        @(posedge ap_clk); #1;
        req_valid = '0;
        @(negedge ap_clk);
        chk("t1_cycle1_valid", longint'(resp_valid), 0);
        @(negedge ap_clk);
        chk("t1_valid", longint'(resp_valid), 1);
        chk("t1_id", longint'(resp_id), 2);
        chk("t1_dout", longint'($signed(resp_dout)), 134217728);
        chk("t1_count_before", longint'(op_count), 0);
        @(negedge ap_clk);
        chk("t1_count_after", longint'(op_count), 1);

        // Test 2: operand extremes
        single(0, 32767, 4095, 134180865);
        single(0, 32767, -4096, -134213632);

        // Test 3: round robin with all requesters valid
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, (i + 1) * 1111, -(i + 3) * 11);
        req_valid = '1;
        ap_rst_n  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge ap_clk);
            if (c < 6) chk("t3_grant", longint'(req_ready), longint'(1) << order[c]);
            if (c >= 2) begin
                chk("t3_resp_valid", longint'(resp_valid), 1);
                chk("t3_resp_id", longint'(resp_id), longint'(order[c-2]));
            end
            @(posedge ap_clk); #1;
            if (c == 5) req_valid = '0;
        end

        // Test 4: backpressure with requesters 1 and 3
        resp_ready = 1'b0;
        set_ops(1, -300, 25);
        set_ops(3, 1234, -56);
        req_valid = 4'b1010;
        acc_cnt   = 0;
        for (int b = 0; b < 8; b++) begin
            @(negedge ap_clk);
            if (b < 5 && (req_ready & req_valid) != '0) acc_cnt++;
            if (b == 0) chk("t4_grant3", longint'(req_ready), 8);
            if (b == 1) chk("t4_grant1", longint'(req_ready), 2);
            if (b >= 2 && b <= 4) begin
                chk("t4_stall_ready", longint'(req_ready), 0);
                chk("t4_hold_valid", longint'(resp_valid), 1);
                chk("t4_hold_id", longint'(resp_id), 3);
                chk("t4_hold_dout", longint'($signed(resp_dout)), -69104);
            end
            if (b == 5) begin
                chk("t4_out0_id", longint'(resp_id), 3);
                chk("t4_out0_dout", longint'($signed(resp_dout)), -69104);
            end
            if (b == 6) begin
                chk("t4_out1_valid", longint'(resp_valid), 1);
                chk("t4_out1_id", longint'(resp_id), 1);
                chk("t4_out1_dout", longint'($signed(resp_dout)), -7500);
            end
            if (b == 7) chk("t4_drained", longint'(resp_valid), 0);
            @(posedge ap_clk); #1;
            if (b == 4) begin
                resp_ready = 1'b1;
                req_valid  = '0;
            end
        end
        chk("t4_accepts", longint'(acc_cnt), 2);

        // Test 5: reset with both stages full
        resp_ready = 1'b0;
        set_ops(2, -5, 7);
        req_valid = 4'b0100;
        @(posedge ap_clk); #1;
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        chk("t5_pre_valid", longint'(resp_valid), 1);
        chk("t5_pre_count", longint'(op_count), 8);
        @(posedge ap_clk); #1;
        ap_rst_n  = 1'b0;
        req_valid = 4'b1001;
        set_ops(0, 77, -3);
        set_ops(3, -1000, 999);
        #1;
        chk("t5_rst_valid", longint'(resp_valid), 0);
        chk("t5_rst_count", longint'(op_count), 0);
        chk("t5_rst_ready", longint'(req_ready), 0);
        @(posedge ap_clk); #1;
        ap_rst_n   = 1'b1;
        resp_ready = 1'b1;
        @(negedge ap_clk);
        chk("t5_first_grant", longint'(req_ready), 1);
        @(posedge ap_clk); #1;
        req_valid[0] = 1'b0;
        @(negedge ap_clk);
        chk("t5_second_grant", longint'(req_ready), 8);
        @(posedge ap_clk); #1;
        req_valid = '0;
        repeat (3) @(negedge ap_clk);

        // Test 6: 65536 handshakes wrap the counter back to zero
        do_reset();
        req_valid = '1;
        ap_rst_n  = 1'b1;
        for (int c = 0; c < 65539; c++) begin
            @(negedge ap_clk);
            if (c == 65537) chk("t6_count_ffff", longint'(op_count), 65535);
            if (c == 65538) begin
                chk("t6_count_wrap", longint'(op_count), 0);
                chk("t6_idle", longint'(resp_valid), 0);
            end
            @(posedge ap_clk); #1;
            if (c == 65535) req_valid = '0;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
